// File: rtl/intr_req_gen.sv
// -----------------------------------------------------------------------------
// intr_req_gen
//
// Request-side companion to the priority interrupt controller. Each source
// (bus b, channel c, flat index b*NCH+c) has an edge detector on its event
// strobe feeding a pending latch. The latches drive the controller's request
// lines, subject to a per-source mask and a post-clear hold-off. The
// controller's encoded grant is taken through a 4-phase valid/ready handshake.
// A grant for a pending source retires it with a one-cycle clear pulse.
//
// Optional feature (compile-time macro INTR_REQ_OVF_EN):
//   When defined, a sticky per-source overflow flag records a second event
//   arriving while the source is already pending. When undefined, ovf is tied
//   to 0 and no detection logic is built.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   evt       per-source event strobes, rising edge detected
//   mask      per-source mask (pending kept, request forced low)
//   req       request lines to the controller
//   gnt_vld   grant valid from the controller
//   gnt_bus   granted bus index
//   gnt_ch    granted channel index
//   gnt_rdy   grant accepted this cycle
//   clr_pls   one-cycle pulse when a source is retired
//   clr_idx   flat index of the retired source, valid with clr_pls
//   err_gnt   sticky flag: grant for an out-of-range or non-pending source
//   pend_cnt  registered population count of the pending latches
//   ovf       sticky per-source overflow (0 unless INTR_REQ_OVF_EN)
// -----------------------------------------------------------------------------
module intr_req_gen #(
  parameter int NCH      = 9,
  parameter int NBUS     = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBUS*NCH-1:0]  evt,
  input  logic [NBUS*NCH-1:0]  mask,
  output logic [NBUS*NCH-1:0]  req,
  input  logic                 gnt_vld,
  input  logic [1:0]           gnt_bus,
  input  logic [3:0]           gnt_ch,
  output logic                 gnt_rdy,
  output logic                 clr_pls,
  output logic [5:0]           clr_idx,
  output logic                 err_gnt,
  output logic [5:0]           pend_cnt,
  output logic [NBUS*NCH-1:0]  ovf
);

  localparam int N = NBUS * NCH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    WAITDROP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [N-1:0]   evt_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   rise_p1;
  logic [N-1:0]   pend;
  logic [N-1:0]   hold;
  logic [N-1:0]   clr_vec;
  logic [2:0]     hold_cnt [N];

  logic [5:0]     gnt_idx;
  logic [5:0]     idx_q;
  logic           gnt_in_range;
  logic           pend_hit;
  logic           gnt_ok;
  logic           accept_ok;
  logic           accept_bad;

  function automatic logic [5:0] popcnt(input logic [N-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: edge detection. The rise is registered so that the request path
  // is two registers away from evt and never combinational from it.
  // ---------------------------------------------------------------------------
  assign rise = evt & ~evt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q   <= '0;
      rise_p1 <= '0;
    end else begin
      evt_q   <= evt;
      rise_p1 <= rise;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: pending latches and hold-off counters.
  // A set arriving in the same cycle as the clear of that source wins, so an
  // event coinciding with its own retirement is not lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N; i++) begin
      clr_vec[i] = (state == CLEAR) && (idx_q == 6'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < N; i++) begin
        hold_cnt[i] <= 3'd0;
      end
    end else begin
      pend <= (pend & ~clr_vec) | rise_p1;
      for (int i = 0; i < N; i++) begin
        if (clr_vec[i]) begin
          hold_cnt[i] <= 3'(HOLD_CYC);
        end else if (hold_cnt[i] != 3'd0) begin
          hold_cnt[i] <= hold_cnt[i] - 3'd1;
        end
      end
    end
  end

  always_comb begin
    hold = '0;
    for (int i = 0; i < N; i++) begin
      hold[i] = (hold_cnt[i] != 3'd0);
    end
  end

  assign req = pend & ~mask & ~hold;

  // ---------------------------------------------------------------------------
  // Stage 3: registered pending count, one cycle behind pend.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= 6'd0;
    end else begin
      pend_cnt <= popcnt(pend);
    end
  end

  // ---------------------------------------------------------------------------
  // Grant decode. The pending lookup is a compare loop so that an out-of-range
  // flat index never addresses past the end of pend.
  // ---------------------------------------------------------------------------
  assign gnt_idx      = 6'(gnt_bus) * 6'(NCH) + 6'(gnt_ch);
  assign gnt_in_range = (int'(gnt_bus) < NBUS) && (int'(gnt_ch) < NCH);

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == 6'(i)) begin
        pend_hit = pend[i];
      end
    end
  end

  assign gnt_ok     = gnt_in_range && pend_hit;
  assign accept_ok  = (state == IDLE) && gnt_vld && gnt_ok;
  assign accept_bad = (state == IDLE) && gnt_vld && !gnt_ok;

  // ---------------------------------------------------------------------------
  // Grant FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_ok) begin
          state_nxt = CLEAR;
        end else if (accept_bad) begin
          state_nxt = WAITDROP;
        end
      end
      CLEAR: begin
        state_nxt = WAITDROP;
      end
      WAITDROP: begin
        // Each grant must be followed by gnt_vld dropping before the next.
        if (!gnt_vld) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant FSM: outputs. gnt_rdy is masked during reset so it reads 0 there.
  always_comb begin
    gnt_rdy = (state == IDLE) && gnt_vld && !rst;
    clr_pls = (state == CLEAR);
    clr_idx = (state == CLEAR) ? idx_q : 6'd0;
  end

  // Latched grant index and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 6'd0;
      err_gnt <= 1'b0;
    end else begin
      if (accept_ok) begin
        idx_q <= gnt_idx;
      end
      if (accept_bad) begin
        err_gnt <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional overflow tracking
  // ---------------------------------------------------------------------------
`ifdef INTR_REQ_OVF_EN
  logic [N-1:0] ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= '0;
    end else begin
      // A clear of the source takes precedence and also masks a coincident
      // rise, which is absorbed by the set-wins rule on pend instead.
      ovf_r <= (ovf_r | (rise_p1 & pend)) & ~clr_vec;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_intr_req_gen.sv
// -----------------------------------------------------------------------------
// tb_intr_req_gen
//
// Directed testbench for intr_req_gen with NCH=9, NBUS=3, HOLD_CYC=2.
// Each scenario task drives stimulus and checks outputs inline; inputs are
// driven and outputs sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_intr_req_gen;

  localparam int NCH  = 9;
  localparam int NBUS = 3;
  localparam int N    = NCH * NBUS;

  logic          clk;
  logic          rst;
  logic [N-1:0]  evt;
  logic [N-1:0]  mask;
  logic [N-1:0]  req;
  logic          gnt_vld;
  logic [1:0]    gnt_bus;
  logic [3:0]    gnt_ch;
  logic          gnt_rdy;
  logic          clr_pls;
  logic [5:0]    clr_idx;
  logic          err_gnt;
  logic [5:0]    pend_cnt;
  logic [N-1:0]  ovf;

  int tests_run;
  int tests_failed;

  intr_req_gen #(
    .NCH      (NCH),
    .NBUS     (NBUS),
    .HOLD_CYC (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt      (evt),
    .mask     (mask),
    .req      (req),
    .gnt_vld  (gnt_vld),
    .gnt_bus  (gnt_bus),
    .gnt_ch   (gnt_ch),
    .gnt_rdy  (gnt_rdy),
    .clr_pls  (clr_pls),
    .clr_idx  (clr_idx),
    .err_gnt  (err_gnt),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire a pending source with a clean 4-phase grant, then let hold expire.
  task automatic do_grant(input int b, input int c);
    gnt_vld = 1'b1;
    gnt_bus = 2'(b);
    gnt_ch  = 4'(c);
    step();
    gnt_vld = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    evt     = '0;
    mask    = '0;
    gnt_vld = 1'b0;
    gnt_bus = 2'd0;
    gnt_ch  = 4'd0;
    repeat (2) step();
    tests_run++; if (req !== '0) begin tests_failed++; $display("FAIL reset_req: got %h want 0", req); end
    tests_run++; if (pend_cnt !== 6'd0) begin tests_failed++; $display("FAIL reset_pend_cnt: got %0d want 0", pend_cnt); end
    tests_run++; if (err_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_gnt); end
    tests_run++; if (clr_pls !== 1'b0 || clr_idx !== 6'd0) begin tests_failed++; $display("FAIL reset_clr: got pls=%b idx=%0d want 0/0", clr_pls, clr_idx); end
    tests_run++; if (gnt_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy: got %b want 0", gnt_rdy); end
    tests_run++; if (ovf !== '0) begin tests_failed++; $display("FAIL reset_ovf: got %h want 0", ovf); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_basic_grant();
    evt[13] = 1'b1;                      // cycle 0
    #1;
    tests_run++; if (req[13] !== 1'b0) begin tests_failed++; $display("FAIL basic_req_c0: got %b want 0", req[13]); end
    step();                              // cycle 1
    evt[13] = 1'b0;
    tests_run++; if (req[13] !== 1'b0) begin tests_failed++; $display("FAIL basic_req_c1: got %b want 0", req[13]); end
    step();                              // cycle 2
    tests_run++; if (req[13] !== 1'b1) begin tests_failed++; $display("FAIL basic_req_c2: got %b want 1", req[13]); end
    tests_run++; if (pend_cnt !== 6'd0) begin tests_failed++; $display("FAIL basic_cnt_c2: got %0d want 0", pend_cnt); end
    step();                              // cycle 3
    tests_run++; if (pend_cnt !== 6'd1) begin tests_failed++; $display("FAIL basic_cnt_c3: got %0d want 1", pend_cnt); end
    step();                              // cycle 4
    gnt_vld = 1'b1;
    gnt_bus = 2'd1;
    gnt_ch  = 4'd4;
    #1;
    tests_run++; if (gnt_rdy !== 1'b1) begin tests_failed++; $display("FAIL basic_rdy_c4: got %b want 1", gnt_rdy); end
    tests_run++; if (clr_pls !== 1'b0) begin tests_failed++; $display("FAIL basic_clr_c4: got %b want 0", clr_pls); end
    step();                              // cycle 5
    tests_run++; if (clr_pls !== 1'b1 || clr_idx !== 6'd13) begin tests_failed++; $display("FAIL basic_clr_c5: got pls=%b idx=%0d want 1/13", clr_pls, clr_idx); end
    tests_run++; if (gnt_rdy !== 1'b0) begin tests_failed++; $display("FAIL basic_rdy_c5: got %b want 0", gnt_rdy); end
    gnt_vld = 1'b0;
    step();                              // cycle 6
    tests_run++; if (req[13] !== 1'b0 || clr_pls !== 1'b0) begin tests_failed++; $display("FAIL basic_c6: got req=%b pls=%b want 0/0", req[13], clr_pls); end
    step();                              // cycle 7
    tests_run++; if (pend_cnt !== 6'd0 || req[13] !== 1'b0) begin tests_failed++; $display("FAIL basic_c7: got cnt=%0d req=%b want 0/0", pend_cnt, req[13]); end
    tests_run++; if (err_gnt !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %b want 0", err_gnt); end
    repeat (3) step();
  endtask

  task automatic test_mask();
    mask[0] = 1'b1;
    evt[0]  = 1'b1;
    step();
    evt[0] = 1'b0;
    step();
    tests_run++; if (req[0] !== 1'b0) begin tests_failed++; $display("FAIL mask_req: got %b want 0", req[0]); end
    step();
    tests_run++; if (pend_cnt !== 6'd1 || req[0] !== 1'b0) begin tests_failed++; $display("FAIL mask_cnt: got cnt=%0d req=%b want 1/0", pend_cnt, req[0]); end
    mask[0] = 1'b0;
    step();
    tests_run++; if (req[0] !== 1'b1) begin tests_failed++; $display("FAIL mask_unmask: got %b want 1", req[0]); end
    do_grant(0, 0);
    tests_run++; if (pend_cnt !== 6'd0 || req[0] !== 1'b0) begin tests_failed++; $display("FAIL mask_retire: got cnt=%0d req=%b want 0/0", pend_cnt, req[0]); end
  endtask

  task automatic test_bad_grant();
    evt[3] = 1'b1;
    evt[9] = 1'b1;
    step();
    evt = '0;
    repeat (2) step();
    tests_run++; if (pend_cnt !== 6'd2) begin tests_failed++; $display("FAIL bad_setup: got %0d want 2", pend_cnt); end
    // out-of-range bus 2, channel 12
    gnt_vld = 1'b1; gnt_bus = 2'd2; gnt_ch = 4'd12;
    #1;
    tests_run++; if (gnt_rdy !== 1'b1) begin tests_failed++; $display("FAIL bad_oor_rdy: got %b want 1", gnt_rdy); end
    step();
    tests_run++; if (err_gnt !== 1'b1 || clr_pls !== 1'b0) begin tests_failed++; $display("FAIL bad_oor: got err=%b pls=%b want 1/0", err_gnt, clr_pls); end
    gnt_vld = 1'b0;
    step();
    tests_run++; if (clr_pls !== 1'b0) begin tests_failed++; $display("FAIL bad_oor_noclr: got %b want 0", clr_pls); end
    step();
    // channel 9 on bus 0 aliases flat index 9, which is pending: still an error
    gnt_vld = 1'b1; gnt_bus = 2'd0; gnt_ch = 4'd9;
    #1;
    tests_run++; if (gnt_rdy !== 1'b1) begin tests_failed++; $display("FAIL bad_alias_rdy: got %b want 1", gnt_rdy); end
    step();
    tests_run++; if (clr_pls !== 1'b0) begin tests_failed++; $display("FAIL bad_alias_noclr: got %b want 0", clr_pls); end
    gnt_vld = 1'b0;
    repeat (2) step();
    tests_run++; if (req[9] !== 1'b1 || req[3] !== 1'b1 || pend_cnt !== 6'd2) begin tests_failed++; $display("FAIL bad_alias_pend: got r9=%b r3=%b cnt=%0d want 1/1/2", req[9], req[3], pend_cnt); end
    // in range but not pending
    gnt_vld = 1'b1; gnt_bus = 2'd0; gnt_ch = 4'd1;
    step();
    tests_run++; if (clr_pls !== 1'b0 || err_gnt !== 1'b1) begin tests_failed++; $display("FAIL bad_nopend: got pls=%b err=%b want 0/1", clr_pls, err_gnt); end
    gnt_vld = 1'b0;
    repeat (3) step();
    tests_run++; if (pend_cnt !== 6'd2 || err_gnt !== 1'b1) begin tests_failed++; $display("FAIL bad_sticky: got cnt=%0d err=%b want 2/1", pend_cnt, err_gnt); end
    do_grant(0, 3);
    do_grant(1, 0);
    tests_run++; if (pend_cnt !== 6'd0) begin tests_failed++; $display("FAIL bad_cleanup: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_collision();
    logic [N-1:0] ovf_exp;
    evt[7] = 1'b1;
    step();
    evt[7] = 1'b0;
    repeat (2) step();
    tests_run++; if (req[7] !== 1'b1) begin tests_failed++; $display("FAIL coll_setup: got %b want 1", req[7]); end
    // grant 7 and raise evt[7] so its registered rise lands on the CLEAR cycle
    gnt_vld = 1'b1; gnt_bus = 2'd0; gnt_ch = 4'd7;
    evt[7] = 1'b1;
    #1;
    tests_run++; if (gnt_rdy !== 1'b1) begin tests_failed++; $display("FAIL coll_rdy: got %b want 1", gnt_rdy); end
    step();
    tests_run++; if (clr_pls !== 1'b1 || clr_idx !== 6'd7) begin tests_failed++; $display("FAIL coll_clr: got pls=%b idx=%0d want 1/7", clr_pls, clr_idx); end
    gnt_vld = 1'b0;
    evt[7]  = 1'b0;
    step();
    tests_run++; if (req[7] !== 1'b0) begin tests_failed++; $display("FAIL coll_hold1: got %b want 0", req[7]); end
    step();
    tests_run++; if (req[7] !== 1'b0 || pend_cnt !== 6'd1) begin tests_failed++; $display("FAIL coll_hold2: got req=%b cnt=%0d want 0/1", req[7], pend_cnt); end
    step();
    tests_run++; if (req[7] !== 1'b1) begin tests_failed++; $display("FAIL coll_reassert: got %b want 1", req[7]); end
    tests_run++; if (ovf !== '0) begin tests_failed++; $display("FAIL coll_ovf_none: got %h want 0", ovf); end
    // second rise while still pending
    evt[7] = 1'b1;
    step();
    evt[7] = 1'b0;
    step();
    ovf_exp = '0;
`ifdef INTR_REQ_OVF_EN
    ovf_exp[7] = 1'b1;
`endif
    tests_run++; if (ovf !== ovf_exp) begin tests_failed++; $display("FAIL coll_ovf_set: got %h want %h", ovf, ovf_exp); end
    gnt_vld = 1'b1; gnt_bus = 2'd0; gnt_ch = 4'd7;
    step();
    tests_run++; if (clr_pls !== 1'b1 || clr_idx !== 6'd7) begin tests_failed++; $display("FAIL coll_clr2: got pls=%b idx=%0d want 1/7", clr_pls, clr_idx); end
    gnt_vld = 1'b0;
    step();
    tests_run++; if (ovf !== '0 || req[7] !== 1'b0) begin tests_failed++; $display("FAIL coll_ovf_clr: got ovf=%h req=%b want 0/0", ovf, req[7]); end
    repeat (3) step();
    tests_run++; if (pend_cnt !== 6'd0) begin tests_failed++; $display("FAIL coll_cleanup: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_back_to_back();
    int nclr;
    int nrdy;
    logic [5:0] last_idx;
    nclr = 0;
    nrdy = 0;
    last_idx = 6'd63;
    evt[2]  = 1'b1;
    evt[20] = 1'b1;
    step();
    evt = '0;
    repeat (2) step();
    tests_run++; if (req[2] !== 1'b1 || req[20] !== 1'b1) begin tests_failed++; $display("FAIL b2b_setup: got r2=%b r20=%b want 1/1", req[2], req[20]); end
    gnt_vld = 1'b1; gnt_bus = 2'd0; gnt_ch = 4'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (clr_pls) begin nclr++; last_idx = clr_idx; end
      if (gnt_rdy) nrdy++;
      // retarget mid-hold: must be ignored outside IDLE
      if (k == 2) begin gnt_bus = 2'd2; gnt_ch = 4'd2; end
      step();
    end
    gnt_vld = 1'b0;
    #1;
    if (clr_pls) begin nclr++; last_idx = clr_idx; end
    if (gnt_rdy) nrdy++;
    step();
    tests_run++; if (nclr != 1) begin tests_failed++; $display("FAIL b2b_one_clr: got %0d want 1", nclr); end
    tests_run++; if (nrdy != 1) begin tests_failed++; $display("FAIL b2b_one_rdy: got %0d want 1", nrdy); end
    tests_run++; if (last_idx !== 6'd2) begin tests_failed++; $display("FAIL b2b_first_idx: got %0d want 2", last_idx); end
    tests_run++; if (req[20] !== 1'b1 || req[2] !== 1'b0 || pend_cnt !== 6'd1) begin tests_failed++; $display("FAIL b2b_mid: got r20=%b r2=%b cnt=%0d want 1/0/1", req[20], req[2], pend_cnt); end
    gnt_vld = 1'b1; gnt_bus = 2'd2; gnt_ch = 4'd2;
    #1;
    tests_run++; if (gnt_rdy !== 1'b1) begin tests_failed++; $display("FAIL b2b_rdy2: got %b want 1", gnt_rdy); end
    step();
    tests_run++; if (clr_pls !== 1'b1 || clr_idx !== 6'd20) begin tests_failed++; $display("FAIL b2b_clr2: got pls=%b idx=%0d want 1/20", clr_pls, clr_idx); end
    gnt_vld = 1'b0;
    repeat (4) step();
    tests_run++; if (pend_cnt !== 6'd0) begin tests_failed++; $display("FAIL b2b_cleanup: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_reset_mid();
    evt[5] = 1'b1;
    step();
    evt[5] = 1'b0;
    repeat (2) step();
    tests_run++; if (req[5] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_setup: got %b want 1", req[5]); end
    // park the FSM in WAITDROP with an out-of-range grant held high
    gnt_vld = 1'b1; gnt_bus = 2'd3; gnt_ch = 4'd0;
    step();
    tests_run++; if (gnt_rdy !== 1'b0 || err_gnt !== 1'b1) begin tests_failed++; $display("FAIL rstmid_wait: got rdy=%b err=%b want 0/1", gnt_rdy, err_gnt); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (req !== '0 || pend_cnt !== 6'd0) begin tests_failed++; $display("FAIL rstmid_async: got req=%h cnt=%0d want 0/0", req, pend_cnt); end
    tests_run++; if (err_gnt !== 1'b0) begin tests_failed++; $display("FAIL rstmid_err: got %b want 0", err_gnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests_run++; if (gnt_rdy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_idle: got %b want 1", gnt_rdy); end
    tests_run++; if (req[5] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_req: got %b want 0", req[5]); end
    gnt_vld = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_grant();
    test_mask();
    test_bad_grant();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
